// File: rtl/condlogic_if.sv
// Decode-to-condlogic request bus and the gated write strobes going back to the datapath.
interface condlogic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  // Decode side: issues requests, observes strobes and flags.
  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  // Conditional-execution unit side.
  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV flag register, condition evaluation and
// gating of decoder write requests into datapath write enables.
module condlogic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  condlogic_if.slave  bus
);

  localparam int unsigned FLAG_W = 4;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_ex_delayed_q, cond_ex_delayed_d;
  logic              cond_ex;
  logic [1:0]        flag_write;
  logic              n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Evaluate the condition field against the registered (pre-update) flags.
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next-state for the split N,Z / C,V halves and the delayed condition result.
  always_comb begin
    flag_write        = bus.FlagW & {2{cond_ex}};
    flags_d           = flags_q;
    cond_ex_delayed_d = cond_ex;
    if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q           <= FLAG_RESET;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= cond_ex_delayed_d;
    end
  end

  // Write strobes use the condition captured in Execute; fetch increment always wins for PC.
  always_comb begin
    bus.PCWrite  = (bus.PCS & cond_ex_delayed_q) | bus.NextPC;
    bus.RegWrite = bus.RegW & cond_ex_delayed_q;
    bus.MemWrite = bus.MemW & cond_ex_delayed_q;
    bus.Flags    = flags_q;
    bus.CondEx   = cond_ex;
  end

endmodule

// File: tb/tb_condlogic.sv
// Directed self-checking bench for condlogic.
module tb_condlogic;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  condlogic_if bus ();

  condlogic #(.FLAG_RESET(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Cond     = 4'b1110;
    bus.ALUFlags = 4'b0000;
    bus.FlagW    = 2'b00;
    bus.PCS      = 1'b0;
    bus.NextPC   = 1'b0;
    bus.RegW     = 1'b0;
    bus.MemW     = 1'b0;
  endtask

  // Load flags with an always-executed flag-setting op; leaves CondExDelayed = 1.
  task automatic load_flags(input logic [3:0] v);
    idle_inputs();
    bus.Cond     = 4'b1110;
    bus.FlagW    = 2'b11;
    bus.ALUFlags = v;
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset        = 1'b1;
    bus.FlagW    = 2'b11;
    bus.ALUFlags = 4'b1111;
    bus.RegW     = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", bus.Flags);
    end
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWrite);
    end
    reset = 1'b0;
    idle_inputs();
    bus.NextPC = 1'b1;
    #1;
    checks++;
    if (bus.PCWrite !== 1'b1) begin
      errors++; $display("FAIL reset_nextpc: got %b want 1", bus.PCWrite);
    end
    bus.NextPC = 1'b0;
  endtask

  task automatic test_cond_sweep();
    logic [3:0]  sw_flags [8];
    logic [15:0] sw_mask  [8];
    logic [15:0] mask;
    sw_flags[0] = 4'b0000; sw_mask[0] = 16'h56AA;
    sw_flags[1] = 4'b1001; sw_mask[1] = 16'h565A;
    sw_flags[2] = 4'b0100; sw_mask[2] = 16'h66A9;
    sw_flags[3] = 4'b0010; sw_mask[3] = 16'h55A6;
    sw_flags[4] = 4'b1000; sw_mask[4] = 16'h6A9A;
    sw_flags[5] = 4'b0001; sw_mask[5] = 16'h6A6A;
    sw_flags[6] = 4'b0110; sw_mask[6] = 16'h66A5;
    sw_flags[7] = 4'b1111; sw_mask[7] = 16'h6655;
    for (int i = 0; i < 8; i++) begin
      load_flags(sw_flags[i]);
      checks++;
      if (bus.Flags !== sw_flags[i]) begin
        errors++; $display("FAIL sweep_load: got %b want %b", bus.Flags, sw_flags[i]);
      end
      mask = sw_mask[i];
      for (int c = 0; c < 16; c++) begin
        bus.Cond = 4'(c);
        #1;
        checks++;
        if (bus.CondEx !== mask[c]) begin
          errors++;
          $display("FAIL sweep_condex flags=%b cond=%b: got %b want %b",
                   sw_flags[i], 4'(c), bus.CondEx, mask[c]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_split_write();
    load_flags(4'b0000);
    bus.Cond = 4'b1110; bus.FlagW = 2'b10; bus.ALUFlags = 4'b1111;
    tick();
    checks++;
    if (bus.Flags !== 4'b1100) begin
      errors++; $display("FAIL split_nz: got %b want 1100", bus.Flags);
    end
    bus.FlagW = 2'b01; bus.ALUFlags = 4'b0000;
    tick();
    checks++;
    if (bus.Flags !== 4'b1100) begin
      errors++; $display("FAIL split_cv_zero: got %b want 1100", bus.Flags);
    end
    bus.FlagW = 2'b01; bus.ALUFlags = 4'b0011;
    tick();
    checks++;
    if (bus.Flags !== 4'b1111) begin
      errors++; $display("FAIL split_cv: got %b want 1111", bus.Flags);
    end
    idle_inputs();
  endtask

  task automatic test_suppression();
    load_flags(4'b0000);
    bus.Cond = 4'b0000; bus.FlagW = 2'b11; bus.ALUFlags = 4'b0100;
    #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin
      errors++; $display("FAIL supp_condex: got %b want 0", bus.CondEx);
    end
    tick();
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++; $display("FAIL supp_flags: got %b want 0000", bus.Flags);
    end
    bus.FlagW = 2'b00; bus.RegW = 1'b1; bus.MemW = 1'b1; bus.PCS = 1'b1; bus.NextPC = 1'b0;
    #1;
    checks++;
    if ({bus.RegWrite, bus.MemWrite, bus.PCWrite} !== 3'b000) begin
      errors++; $display("FAIL supp_strobes: got %b want 000",
                         {bus.RegWrite, bus.MemWrite, bus.PCWrite});
    end
    bus.NextPC = 1'b1;
    #1;
    checks++;
    if (bus.PCWrite !== 1'b1) begin
      errors++; $display("FAIL supp_nextpc_override: got %b want 1", bus.PCWrite);
    end
    idle_inputs();
  endtask

  task automatic test_delayed_cond();
    load_flags(4'b0000);
    bus.Cond = 4'b0001; bus.FlagW = 2'b10; bus.ALUFlags = 4'b0100;
    #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin
      errors++; $display("FAIL delay_condex_exec: got %b want 1", bus.CondEx);
    end
    tick();
    bus.FlagW = 2'b00; bus.RegW = 1'b1; bus.MemW = 1'b1;
    #1;
    checks++;
    if (bus.Flags !== 4'b0100) begin
      errors++; $display("FAIL delay_flags: got %b want 0100", bus.Flags);
    end
    checks++;
    if (bus.CondEx !== 1'b0) begin
      errors++; $display("FAIL delay_condex_wb: got %b want 0", bus.CondEx);
    end
    checks++;
    if ({bus.RegWrite, bus.MemWrite} !== 2'b11) begin
      errors++; $display("FAIL delay_strobes: got %b want 11", {bus.RegWrite, bus.MemWrite});
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL delay_next_regwrite: got %b want 0", bus.RegWrite);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    load_flags(4'b0110);
    bus.RegW = 1'b1; bus.PCS = 1'b1;
    #1;
    checks++;
    if ({bus.RegWrite, bus.PCWrite} !== 2'b11) begin
      errors++; $display("FAIL mid_pre: got %b want 11", {bus.RegWrite, bus.PCWrite});
    end
    reset = 1'b1; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    tick();
    reset = 1'b0; bus.FlagW = 2'b00;
    #1;
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL mid_regwrite: got %b want 0", bus.RegWrite);
    end
    checks++;
    if (bus.PCWrite !== 1'b0) begin
      errors++; $display("FAIL mid_pcwrite: got %b want 0", bus.PCWrite);
    end
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++; $display("FAIL mid_flags: got %b want 0000", bus.Flags);
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_cond_sweep();
    test_split_write();
    test_suppression();
    test_delayed_cond();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/condlogic.md
Name: condlogic

Overview:
- Conditional-execution unit of the multicycle ARM core.
- Sits directly downstream of the decode unit and consumes its FlagW, PCS, NextPC, RegW and MemW.
- Holds the architectural NZCV flag register and evaluates the instruction condition field against those flags.
- Gates the decoder's write requests into the final PCWrite, RegWrite and MemWrite strobes that drive the datapath.

Parameters:
- FLAG_RESET, 4'b0000, reset value of the NZCV register, as {N,Z,C,V}.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- Cond  input  4  Instr[31:28] condition field
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle
- FlagW  input  2  from decode; [1] requests an N,Z update, [0] requests a C,V update
- PCS  input  1  from decode; PC-source write request (branch, or Rd=R15 with RegW)
- NextPC  input  1  from the FSM, via decode; unconditional PC increment (fetch)
- RegW  input  1  from decode; register-file write request
- MemW  input  1  from decode; memory write request
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  data-memory write enable
- Flags  output  4  current registered {N,Z,C,V}, for observability and debug
- CondEx  output  1  combinational condition result against the current Flags

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. No asynchronous paths.
- Reset values:
  - Flags = FLAG_RESET.
  - The internal CondExDelayed register = 0.
  - Consequence: PCWrite = NextPC, and RegWrite = MemWrite = 0, in the cycle after reset.
- CondEx is combinational from Cond and the registered Flags:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: 0 (treated as never-execute; never X).
- Flag register:
  - Split write enables: FlagWrite[1] = FlagW[1] & CondEx; FlagWrite[0] = FlagW[0] & CondEx.
  - On posedge, when not in reset: if FlagWrite[1], {N,Z} <= ALUFlags[3:2]; if FlagWrite[0], {C,V} <= ALUFlags[1:0].
  - Each half holds independently. A flag write uses CondEx computed from the pre-update flags.
- CondExDelayed:
  - Captures CondEx every posedge, unconditionally, when not in reset.
  - It carries the Execute-state condition result into the ALUWB, MemWB and MemWrite states, after flags may already have changed.
- Outputs (combinational):
  - PCWrite = (PCS & CondExDelayed) | NextPC.
  - RegWrite = RegW & CondExDelayed.
  - MemWrite = MemW & CondExDelayed.
- Boundary cases:
  - NextPC overrides a failed condition, so fetch always advances.
  - FlagW=2'b11 with CondEx=0: no flag change.
  - A flag-setting instruction whose own Cond tests the flags it writes uses the old flags, in both the same cycle and the following writeback cycle.
  - reset asserted mid-instruction: Flags and CondExDelayed return to their reset values at the next edge, regardless of the other inputs. Outputs are gated by the cleared CondExDelayed starting in that next cycle.
- Latency:
  - Flags visible 1 cycle after FlagWrite.
  - CondExDelayed lags CondEx by 1 cycle.
  - Write strobes have 0-cycle latency from the request inputs.

Test Plan:
- Reset behaviour: hold reset 2 cycles with FlagW=11 and ALUFlags=1111 -> Flags=0000, RegWrite=0 with RegW=1. Release, drive NextPC=1 -> PCWrite=1.
- Condition sweep: for each Flags value (load via Cond=1110, FlagW=11) and each Cond 0000-1111 -> CondEx matches the table. Example: Flags=1001 (N=1, V=1) gives GE=1, LT=0, GT=1. Cond=1111 gives 0.
- Split write: Flags=0000; cycle 1: FlagW=10, ALUFlags=1111, Cond=1110 -> Flags=1100. Cycle 2: FlagW=01, ALUFlags=0000 -> Flags=1100 (C,V still 0). Cycle 3: FlagW=01, ALUFlags=0011 -> Flags=1111.
- Conditional suppression: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=0100 -> Flags unchanged. Next cycle RegW=1, MemW=1, PCS=1, NextPC=0 -> RegWrite=MemWrite=PCWrite=0.
- Delayed condition: Flags=0000, Cond=0001 (NE); Execute cycle FlagW=10, ALUFlags=0100 -> Z becomes 1. Next cycle RegW=1 -> RegWrite=1, because CondExDelayed captured NE as true before the update.
- Reset mid-instruction: CondExDelayed=1, assert reset for one cycle while RegW=1 -> cycle after the edge shows RegWrite=0 and Flags=0000.
